mainmem_responder: RTL



---
 rtl/mainmem_pkg.sv | 18 +
 rtl/mainmem_pipe.sv | 37 +++
 rtl/mainmem_responder.sv | 99 +++++++++
 3 files changed

// File: rtl/mainmem_pkg.sv
// rtl/mainmem_pkg.sv - shared constants and pipeline stage type for mainmem_responder
// Purpose: default geometry/latency of the main-memory responder and the
//          {valid, data} record carried through its read pipeline.
// Ports:   none (package).
package mainmem_pkg;

  localparam int MAINMEM_ADDR_W     = 16;
  localparam int MAINMEM_DATA_W     = 16;
  localparam int MAINMEM_WORD_IDX_W = 13;
  localparam int MAINMEM_LATENCY    = 4;

  // One slot of the read-return pipeline; valid=0 marks a bubble.
  typedef struct packed {
    logic                      valid;
    logic [MAINMEM_DATA_W-1:0] data;
  } mainmem_stage_t;

endpackage

// File: rtl/mainmem_pipe.sv
// rtl/mainmem_pipe.sv - fixed-depth shift register of read-return stages
// Purpose: delays each issued read slot by exactly LATENCY clock edges.
// Ports:   clk  - rising-edge clock
//          rst  - asynchronous active-high reset, clears every stage
//          head - stage entering the pipeline this cycle
//          tail - registered oldest stage (drives the responder outputs)
module mainmem_pipe
  import mainmem_pkg::*;
#(
  parameter int LATENCY = MAINMEM_LATENCY
) (
  input  logic           clk,
  input  logic           rst,
  input  mainmem_stage_t head,
  output mainmem_stage_t tail
);

  mainmem_stage_t stage_q [LATENCY];

  // Data fields are cleared along with valid so the outputs read as zero
  // immediately on reset instead of holding a stale word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= head;
      for (int i = 1; i < LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tail = stage_q[LATENCY-1];

endmodule

// File: rtl/mainmem_responder.sv
// rtl/mainmem_responder.sv - pipelined fixed-latency single-port word memory
// Purpose: serves cache-fill reads (data_valid exactly LATENCY cycles after
//          issue) and write-through writes, one request per cycle.
// Ports:   clk        - rising-edge clock
//          rst        - asynchronous active-high reset
//          enable     - request strobe
//          wr         - 1 = write, 0 = read (qualified by enable)
//          addr       - byte address, addr[0] ignored, wraps modulo array
//          write_data - write word
//          read_data  - returned word, meaningful while data_valid=1
//          data_valid - one-cycle pulse per read
//          rd_count   - saturating accepted-read count (MAINMEM_STATS_EN)
//          wr_count   - saturating accepted-write count (MAINMEM_STATS_EN)
// Macro:   MAINMEM_STATS_EN adds rd_count/wr_count.
module mainmem_responder
  import mainmem_pkg::*;
#(
  parameter int ADDR_W     = MAINMEM_ADDR_W,
  parameter int DATA_W     = MAINMEM_DATA_W,
  parameter int WORD_IDX_W = MAINMEM_WORD_IDX_W,
  parameter int LATENCY    = MAINMEM_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              data_valid
`ifdef MAINMEM_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  logic [DATA_W-1:0]     mem [2**WORD_IDX_W];
  logic [WORD_IDX_W-1:0] idx;
  logic                  rd_req;
  logic                  wr_req;
  logic                  addr_unused;
  mainmem_stage_t        head;
  mainmem_stage_t        tail;

  // Byte lane bit and bits above the array depth are dropped: aliasing.
  assign idx         = addr[WORD_IDX_W:1];
  assign addr_unused = ^{addr[ADDR_W-1:WORD_IDX_W+1], addr[0]};

  assign rd_req = enable & ~wr;
  assign wr_req = enable & wr;

  // Array is never reset; rst only blocks a write coinciding with it.
  always_ff @(posedge clk) begin
    if (wr_req && !rst) begin
      mem[idx] <= write_data;
    end
  end

  // Word is sampled at issue, so a later write to the same index cannot
  // change an in-flight read. Bubbles carry zero so an undefined address
  // on an idle cycle never reaches read_data.
  always_comb begin
    head       = '0;
    head.valid = rd_req;
    if (rd_req) begin
      head.data = mem[idx];
    end
  end

  mainmem_pipe #(
    .LATENCY(LATENCY)
  ) u_pipe (
    .clk (clk),
    .rst (rst),
    .head(head),
    .tail(tail)
  );

  assign read_data  = tail.data;
  assign data_valid = tail.valid;

`ifdef MAINMEM_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_req && (rd_count != 16'hFFFF)) begin
        rd_count <= rd_count + 16'd1;
      end
      if (wr_req && (wr_count != 16'hFFFF)) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end
`endif

endmodule
